// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between several
// core memory ports; one registered transaction in flight at a time.
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS-1:0]   m_req,
    input  logic [NUM_MASTERS-1:0]   m_we,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]   m_ready,
    output logic [31:0]              m_rdata,
    output logic                     mem_valid,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ready,
    input  logic [31:0]              mem_rdata,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state, state_n;

    logic [ID_W-1:0]        last_grant, last_grant_n;
    logic [ID_W-1:0]        grant_id_n;
    logic [NUM_MASTERS-1:0] m_ready_n;
    logic [31:0]            m_rdata_n;
    logic                   mem_valid_n;
    logic                   mem_we_n;
    logic [31:0]            mem_addr_n;
    logic [31:0]            mem_wdata_n;
    logic [3:0]             mem_wstrb_n;
    logic                   busy_n;

    logic            found;
    logic [ID_W-1:0] pick;
    int              sel;
    int              cand;

    // Scan starts just after the previous owner so priority rotates.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        sel   = 0;
        cand  = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(last_grant) + k) % NUM_MASTERS;
            if (!found && m_req[cand]) begin
                found = 1'b1;
                sel   = cand;
                pick  = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_id_n   = grant_id;
        m_ready_n    = m_ready;
        m_rdata_n    = m_rdata;
        mem_valid_n  = mem_valid;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_wstrb_n  = mem_wstrb;
        busy_n       = busy;

        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_id_n  = pick;
                    mem_valid_n = 1'b1;
                    mem_we_n    = m_we[sel];
                    mem_addr_n  = m_addr[sel*32 +: 32];
                    mem_wdata_n = m_wdata[sel*32 +: 32];
                    mem_wstrb_n = m_we[sel] ? m_wstrb[sel*4 +: 4] : 4'b0;
                    busy_n      = 1'b1;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    m_rdata_n    = mem_rdata;
                    mem_valid_n  = 1'b0;
                    m_ready_n    = NUM_MASTERS'(1) << grant_id;
                    last_grant_n = grant_id;
                    state_n      = RESP;
                end
            end
            RESP: begin
                m_ready_n = '0;
                m_rdata_n = '0;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_MASTERS - 1);
            grant_id   <= '0;
            m_ready    <= '0;
            m_rdata    <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant_id   <= grant_id_n;
            m_ready    <= m_ready_n;
            m_rdata    <= m_rdata_n;
            mem_valid  <= mem_valid_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_wstrb  <= mem_wstrb_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline model of each transaction checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*32-1:0] m_addr = '0;
    logic [N*32-1:0] m_wdata = '0;
    logic [N*4-1:0]  m_wstrb = '0;
    logic [N-1:0]    m_ready;
    logic [31:0]     m_rdata;
    logic            mem_valid;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready = 1'b0;
    logic [31:0]     mem_rdata = '0;
    logic            busy;
    logic [IW-1:0]   grant_id;

    mem_arbiter #(.NUM_MASTERS(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // ---------------- transaction-timeline model ----------------
    int          cyc = 0;
    bit          have = 1'b0;
    int          md_owner = 0;
    int          t_grant = 0;
    int          t_done = -1;
    int          last = N - 1;
    logic        md_we = 1'b0;
    logic [31:0] md_addr = '0;
    logic [31:0] md_wdata = '0;
    logic [3:0]  md_wstrb = '0;
    logic [31:0] md_rdata = '0;
    int          glog[$];
    int          win;

    function automatic int rr_pick(input int lg, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (lg + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    assign win = rr_pick(last, m_req);

    function automatic bit arb_free();
        return !have || (t_done >= 0 && cyc >= t_done + 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      <= 0;
            have     <= 1'b0;
            md_owner <= 0;
            t_grant  <= 0;
            t_done   <= -1;
            last     <= N - 1;
            md_we    <= 1'b0;
            md_addr  <= '0;
            md_wdata <= '0;
            md_wstrb <= '0;
            md_rdata <= '0;
        end else begin
            if (arb_free()) begin
                if (win >= 0) begin
                    have     <= 1'b1;
                    md_owner <= win;
                    t_grant  <= cyc;
                    t_done   <= -1;
                    md_we    <= m_we[win];
                    md_addr  <= m_addr[win*32 +: 32];
                    md_wdata <= m_wdata[win*32 +: 32];
                    md_wstrb <= m_wstrb[win*4 +: 4];
                    glog.push_back(win);
                end
            end else if (t_done < 0 && cyc > t_grant && mem_ready) begin
                t_done   <= cyc;
                md_rdata <= mem_rdata;
                last     <= md_owner;
            end
            cyc <= cyc + 1;
        end
    end

    function automatic logic e_valid();
        return have && cyc > t_grant && (t_done < 0 || cyc <= t_done);
    endfunction

    function automatic logic e_busy();
        return have && cyc > t_grant && (t_done < 0 || cyc <= t_done + 1);
    endfunction

    function automatic logic e_pulse();
        return have && t_done >= 0 && cyc == t_done + 1;
    endfunction

    always @(negedge clk) begin
        chk("mem_valid", 32'(mem_valid), 32'(e_valid()));
        chk("busy", 32'(busy), 32'(e_busy()));
        chk("m_ready", 32'(m_ready),
            e_pulse() ? 32'(1) << md_owner : 32'(0));
        chk("m_rdata", m_rdata, e_pulse() ? md_rdata : 32'(0));
        chk("grant_id", 32'(grant_id), 32'(md_owner));
        chk("mem_we", 32'(mem_we), 32'(md_we));
        chk("mem_addr", mem_addr, md_addr);
        chk("mem_wdata", mem_wdata, md_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), md_we ? 32'(md_wstrb) : 32'(0));
    end

    // ---------------- masters and memory ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    bit          tie_hi = 1'b1;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic [31:0] rd_salt = '0;
    int          rdy_cnt[N];
    int          dlog[$];

    function automatic txn_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        t.wstrb = s;
        return t;
    endfunction

    task automatic drive();
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        if (q0.size() > 0) begin
            m_req[0]       = 1'b1;
            m_we[0]        = q0[0].we;
            m_addr[31:0]   = q0[0].addr;
            m_wdata[31:0]  = q0[0].wdata;
            m_wstrb[3:0]   = q0[0].wstrb;
        end
        if (q1.size() > 0) begin
            m_req[1]       = 1'b1;
            m_we[1]        = q1[0].we;
            m_addr[63:32]  = q1[0].addr;
            m_wdata[63:32] = q1[0].wdata;
            m_wstrb[7:4]   = q1[0].wstrb;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_ready != '0) dlog.push_back(int'(grant_id));
        if (m_ready[0]) begin
            rdy_cnt[0]++;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (m_ready[1]) begin
            rdy_cnt[1]++;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (tie_hi) begin
            mem_ready = 1'b1;
            wcnt = 0;
        end else if (mem_valid) begin
            mem_ready = (wcnt >= mem_wait);
            wcnt++;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
        mem_rdata = rd_salt ^ mem_addr;
        drive();
    endtask

    task automatic run_until_idle(input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !busy && !mem_valid)
                return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout after %0d cycles, busy %b required 0",
                 name, maxc, busy);
    endtask

    task automatic wait_grant(input int id, input string name);
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_valid && int'(grant_id) == id) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no grant to master %0d within 40 cycles", name, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        rdy_cnt[0] = 0;
        rdy_cnt[1] = 0;

        // basic read after reset, zero-wait memory
        rd_salt = 32'h00A00513 ^ 32'h0000_0360;
        q0.push_back(mk(1'b0, 32'h360, 32'h0, 4'hF));
        drive();
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(mem_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("t1_valid_c1", 32'(mem_valid), 32'd1);
        chk("t1_addr_c1", mem_addr, 32'h360);
        step();
        chk("t1_ready_c2", 32'(m_ready), 32'd1);
        chk("t1_rdata_c2", m_rdata, 32'h00A00513);
        step();
        chk("t1_busy_c3", 32'(busy), 32'd0);
        chk("t1_ready_c3", 32'(m_ready), 32'd0);

        // fairness: both masters continuously requesting
        rd_salt = 32'h5A5A_0F0F;
        rst = 1'b1;
        step();
        rst = 1'b0;
        glog.delete();
        dlog.delete();
        rdy_cnt[0] = 0;
        rdy_cnt[1] = 0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF));
            q1.push_back(mk(1'b0, 32'h800 + 32'(i * 4), 32'h0, 4'hF));
        end
        drive();
        run_until_idle(60, "fair_idle");
        chk("fair_cnt0", 32'(rdy_cnt[0]), 32'd3);
        chk("fair_cnt1", 32'(rdy_cnt[1]), 32'd3);
        chk("fair_dlog_len", 32'(dlog.size()), 32'd6);
        chk("fair_glog_len", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < dlog.size()) chk("fair_dut_order", 32'(dlog[i]), 32'(i % 2));
            if (i < glog.size()) chk("fair_model_order", 32'(glog[i]), 32'(i % 2));
        end

        // master 1 write alongside master 0 read
        q0.push_back(mk(1'b0, 32'h2000, 32'h1234_5678, 4'hF));
        q1.push_back(mk(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b0011));
        drive();
        wait_grant(0, "wr_grant0");
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_wstrb", 32'(mem_wstrb), 32'd0);
        wait_grant(1, "wr_grant1");
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", mem_addr, 32'h1000);
        chk("wr_wstrb", 32'(mem_wstrb), 32'b0011);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        run_until_idle(20, "wr_idle");

        // slow memory: four wait cycles after grant
        tie_hi = 1'b0;
        mem_wait = 4;
        q0.push_back(mk(1'b0, 32'h200, 32'h0, 4'hF));
        q1.push_back(mk(1'b0, 32'h204, 32'h0, 4'hF));
        drive();
        wait_grant(0, "wait_grant0");
        vcnt = 1;
        for (int i = 0; i < 20 && mem_valid; i++) begin
            step();
            if (mem_valid) vcnt++;
        end
        chk("wait_valid_cycles", 32'(vcnt), 32'd5);
        chk("wait_ready_after", 32'(m_ready), 32'd1);
        run_until_idle(40, "wait_idle");

        // asynchronous reset in the middle of a transaction
        mem_wait = 10;
        q0.push_back(mk(1'b0, 32'h300, 32'h0, 4'hF));
        drive();
        wait_grant(0, "rst_grant");
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        q0.delete();
        q1.delete();
        tie_hi = 1'b1;
        q0.push_back(mk(1'b0, 32'h400, 32'h0, 4'hF));
        q1.push_back(mk(1'b0, 32'h404, 32'h0, 4'hF));
        step();
        rst = 1'b0;
        for (int i = 0; i < 10 && !mem_valid; i++) step();
        chk("rst_first_grant", 32'(grant_id), 32'd0);
        chk("rst_first_valid", 32'(mem_valid), 32'd1);
        run_until_idle(30, "rst_idle");

        // master 0 withdraws its request right after grant
        q0.push_back(mk(1'b0, 32'h500, 32'h0, 4'hF));
        drive();
        wait_grant(0, "drop_grant");
        q0.delete();
        drive();
        step();
        chk("drop_ready", 32'(m_ready), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_valid) vcnt++;
        end
        chk("drop_no_regrant", 32'(vcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one single-ported unified memory between NUM_MASTERS core memory ports (instruction fetch and/or load-store units).
- Sits between the per-core memory interfaces and the shared imem/dmem model; one transaction is in flight at a time.
- Each transaction is latched at grant. It completes with a one-cycle ready pulse to its owner.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 1..8.
- ID_W, 3, width of grant_id; must be >= clog2(NUM_MASTERS), minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- m_req  in  NUM_MASTERS  per-master request; held high until that master's m_ready pulse.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_addr  in  NUM_MASTERS*32  per-master byte address; master i at bits [32i+31:32i].
- m_wdata  in  NUM_MASTERS*32  per-master write data.
- m_wstrb  in  NUM_MASTERS*4  per-master byte strobes.
- m_ready  out  NUM_MASTERS  one-hot completion pulse, one cycle.
- m_rdata  out  32  read data, shared by all masters; valid only in the m_ready cycle.
- mem_valid  out  1  request to memory.
- mem_we  out  1  latched write enable.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_wstrb  out  4  latched strobes; forced to 0 for reads.
- mem_ready  in  1  memory completes the transaction this cycle; mem_rdata is valid with it.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in ISSUE and RESP.
- grant_id  out  ID_W  index of the current or most recent owner.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; all outputs 0.
  - last_grant=NUM_MASTERS-1, so master 0 has first priority.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - If no m_req bit is set, stay in IDLE.
  - Otherwise pick the first set bit in the order last_grant+1, last_grant+2, … modulo NUM_MASTERS.
  - Latch that master's we/addr/wdata/wstrb into the mem_* registers, set grant_id, assert mem_valid, go to ISSUE.
- ISSUE:
  - mem_valid and the mem_* fields stay constant until mem_ready=1.
  - On mem_ready: capture mem_rdata into m_rdata, deassert mem_valid, set m_ready[grant_id]=1, update last_grant=grant_id, go to RESP.
  - mem_ready is ignored when the state is not ISSUE.
- RESP:
  - m_ready pulse is visible for exactly one cycle; no arbitration happens in this state.
  - Next state is IDLE; m_ready and m_rdata clear to 0 on that edge.
- Latency:
  - Request sampled in IDLE at cycle t → mem_valid high at t+1.
  - Zero-wait memory (mem_ready high at t+1) → m_ready at t+2 → back in IDLE at t+3.
  - Per-transaction occupancy is 3 + memory wait cycles.
- Master protocol:
  - A master drops or changes m_req on the edge where it samples m_ready, so IDLE sees the updated value.
  - Fields are latched at grant; dropping m_req after grant does not abort the transaction, and it still completes.
- Fairness:
  - With all masters requesting continuously, grants rotate 0,1,…,N-1,0.
  - No master waits more than NUM_MASTERS-1 transactions.
- Lone requester: it is granted back-to-back regardless of last_grant.
- NUM_MASTERS=1: always grants master 0; the FSM and timing are unchanged.
- Reads: mem_wstrb=0 and mem_wdata are latched but don't-care.
- Writes: m_rdata still captures mem_rdata; its value is don't-care to the master.

Test Plan:
- Reset then m_req=01, m_we=0, m_addr0=0x360, mem_ready tied high, mem_rdata=0x00A00513 → mem_valid at cycle 1 with mem_addr=0x360; m_ready=01 and m_rdata=0x00A00513 at cycle 2; IDLE at cycle 3.
- m_req=11 held continuously for 6 transactions → grant_id sequence 0,1,0,1,0,1; each master gets exactly 3 m_ready pulses.
- Master 1 write: addr 0x1000, wdata 0xDEADBEEF, wstrb 0011 → mem_we=1, mem_addr=0x1000, mem_wstrb=0011, mem_wdata=0xDEADBEEF; a concurrent master 0 read gets mem_wstrb=0000.
- mem_ready held low 4 cycles after grant → mem_valid and mem_addr stable for 5 cycles; m_ready exactly one cycle after mem_ready; other requests wait, no overlap.
- rst pulsed while in ISSUE → asynchronously mem_valid=0, busy=0, m_ready=0; after release with m_req=11, master 0 is granted first.
- Master 0 drops m_req the cycle after grant → transaction still completes with m_ready=01; no second grant to master 0.
